// File: rtl/spatial_filter_conv3x3.sv
// 3x3 window convolution engine, four run-time modes, 4-stage pipeline.
// Ports: clk/reset_n, window in (valid/ready), mode/threshold per beat,
// coefficient write port, filtered pixel out (valid/ready).
`timescale 1ns/1ps
module spatial_filter_conv3x3 #(
    parameter int PIXEL_W  = 8,
    parameter int COEF_W   = 8,
    parameter int SHIFT    = 0,
    parameter int THRESH_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9*PIXEL_W-1:0]  i_pixel_data,
    input  logic                  i_pixel_data_valid,
    output logic                  o_pixel_ready,
    input  logic [1:0]            i_mode,
    input  logic [THRESH_W-1:0]   i_threshold,
    input  logic                  i_coef_we,
    input  logic [3:0]            i_coef_addr,
    input  logic [COEF_W-1:0]     i_coef_data,
    output logic [PIXEL_W-1:0]    o_convoluted_data,
    output logic                  o_convoluted_data_valid,
    input  logic                  i_out_ready
);
    localparam int ACC_W = PIXEL_W + COEF_W + 5;
    localparam int PRD_W = PIXEL_W + 1 + COEF_W;
    localparam int SQ_W  = 2 * ACC_W;
    localparam int CMP_W = (SQ_W > THRESH_W) ? SQ_W : THRESH_W;
    localparam int BOX_W = ACC_W + 14;
    localparam logic [PIXEL_W-1:0] PMAX = '1;

    logic adv;
    assign adv = !o_convoluted_data_valid || i_out_ready;
    assign o_pixel_ready = adv;

    logic signed [COEF_W-1:0] coef [9];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++)
                coef[i] <= (i == 4) ? COEF_W'(1) : '0;
        end else if (i_coef_we && i_coef_addr < 4'd9) begin
            coef[i_coef_addr] <= i_coef_data;
        end
    end

    // S1: per-tap products with the user kernel
    logic [PIXEL_W-1:0]      tap_in [9];
    logic                    v1;
    logic [1:0]              m1;
    logic [THRESH_W-1:0]     t1;
    logic [PIXEL_W-1:0]      tap1 [9];
    logic signed [PRD_W-1:0] prd1 [9];

    always_comb begin
        for (int i = 0; i < 9; i++)
            tap_in[i] = i_pixel_data[i*PIXEL_W +: PIXEL_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            m1 <= '0;
            t1 <= '0;
            for (int i = 0; i < 9; i++) begin
                tap1[i] <= '0;
                prd1[i] <= '0;
            end
        end else if (adv) begin
            v1 <= i_pixel_data_valid;
            m1 <= i_mode;
            t1 <= i_threshold;
            for (int i = 0; i < 9; i++) begin
                tap1[i] <= tap_in[i];
                prd1[i] <= $signed({1'b0, tap_in[i]}) * coef[i];
            end
        end
    end

    // S2: Sobel gradients, tap sum and user-kernel sum
    logic signed [ACC_W-1:0] tx [9];
    logic signed [ACC_W-1:0] gx_c, gy_c, bs_c, us_c;
    logic                    v2;
    logic [1:0]              m2;
    logic [THRESH_W-1:0]     t2;
    logic signed [ACC_W-1:0] gx2, gy2, bs2, us2;

    always_comb begin
        bs_c = '0;
        us_c = '0;
        for (int i = 0; i < 9; i++) begin
            tx[i] = $signed(ACC_W'(tap1[i]));
            bs_c  = bs_c + tx[i];
            us_c  = us_c + ACC_W'(prd1[i]);
        end
        gx_c = tx[0] - tx[2] + (tx[3] <<< 1) - (tx[5] <<< 1)
             + tx[6] - tx[8];
        gy_c = tx[0] + (tx[1] <<< 1) + tx[2] - tx[6]
             - (tx[7] <<< 1) - tx[8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2  <= 1'b0;
            m2  <= '0;
            t2  <= '0;
            gx2 <= '0;
            gy2 <= '0;
            bs2 <= '0;
            us2 <= '0;
        end else if (adv) begin
            v2  <= v1;
            m2  <= m1;
            t2  <= t1;
            gx2 <= gx_c;
            gy2 <= gy_c;
            bs2 <= bs_c;
            us2 <= us_c;
        end
    end

    // S3: mode post-processing
    logic [ACC_W-1:0]        ax, ay;
    logic [SQ_W-1:0]         sq;
    logic [ACC_W:0]          mag;
    logic [BOX_W-1:0]        boxp;
    logic [BOX_W-17:0]       boxq;
    logic signed [ACC_W-1:0] us_sh;
    logic [PIXEL_W-1:0]      res_c;
    logic                    v3;
    logic [PIXEL_W-1:0]      r3;

    always_comb begin
        ax    = gx2[ACC_W-1] ? ACC_W'(-gx2) : ACC_W'(gx2);
        ay    = gy2[ACC_W-1] ? ACC_W'(-gy2) : ACC_W'(gy2);
        sq    = SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay);
        mag   = {1'b0, ax} + {1'b0, ay};
        // x7282 >> 16 approximates /9 without rounding up past max
        boxp  = BOX_W'(bs2) * BOX_W'(7282);
        boxq  = boxp[BOX_W-1:16];
        us_sh = us2 >>> SHIFT;
        res_c = '0;
        unique case (m2)
            2'd0: res_c = (CMP_W'(sq) > CMP_W'(t2)) ? PMAX : '0;
            2'd1: res_c = (mag > (ACC_W+1)'(PMAX)) ? PMAX
                                                   : mag[PIXEL_W-1:0];
            2'd2: res_c = (boxq > (BOX_W-16)'(PMAX)) ? PMAX
                                                     : boxq[PIXEL_W-1:0];
            default: begin
                if (us_sh[ACC_W-1])
                    res_c = '0;
                else if (us_sh > $signed(ACC_W'(PMAX)))
                    res_c = PMAX;
                else
                    res_c = us_sh[PIXEL_W-1:0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v3 <= 1'b0;
            r3 <= '0;
        end else if (adv) begin
            v3 <= v2;
            r3 <= res_c;
        end
    end

    // S4: output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_convoluted_data_valid <= 1'b0;
            o_convoluted_data       <= '0;
        end else if (adv) begin
            o_convoluted_data_valid <= v3;
            if (v3)
                o_convoluted_data <= r3;
        end
    end
endmodule

// File: tb/tb_spatial_filter_conv3x3.sv
// Bench for spatial_filter_conv3x3: directed and random beats against
// an arithmetic reference model with an in-order expected queue.
`timescale 1ns/1ps
module tb_spatial_filter_conv3x3;
    localparam int PW = 8;
    localparam int CW = 8;
    localparam int SH = 0;
    localparam int TW = 32;
    localparam int MAXP = (1 << PW) - 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [9*PW-1:0] pix;
    logic           pv;
    logic           prdy;
    logic [1:0]     md;
    logic [TW-1:0]  th;
    logic           cwe;
    logic [3:0]     ca;
    logic [CW-1:0]  cd;
    logic [PW-1:0]  od;
    logic           ov;
    logic           ordy;

    always #5 clk = ~clk;

    spatial_filter_conv3x3 #(
        .PIXEL_W(PW), .COEF_W(CW), .SHIFT(SH), .THRESH_W(TW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_pixel_data(pix),
        .i_pixel_data_valid(pv),
        .o_pixel_ready(prdy),
        .i_mode(md),
        .i_threshold(th),
        .i_coef_we(cwe),
        .i_coef_addr(ca),
        .i_coef_data(cd),
        .o_convoluted_data(od),
        .o_convoluted_data_valid(ov),
        .i_out_ready(ordy)
    );

    int vectors = 0;
    int miscomp = 0;
    int tap [9];
    int cref [9];
    int kx [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    int ky [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    int exp_q [$];
    int acc_q [$];
    int cyc = 0;
    int n_acc = 0;
    bit lat_chk = 1'b0;
    bit held_v = 1'b0;
    logic [PW-1:0] held_d;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int ref_pix(int m, longint thr);
        longint gx, gy, bs, us, r;
        gx = 0; gy = 0; bs = 0; us = 0;
        for (int i = 0; i < 9; i++) begin
            gx += kx[i] * tap[i];
            gy += ky[i] * tap[i];
            bs += tap[i];
            us += cref[i] * tap[i];
        end
        case (m)
            0: r = (gx * gx + gy * gy > thr) ? MAXP : 0;
            1: begin
                r = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (r > MAXP) r = MAXP;
            end
            2: r = (bs * 7282) >>> 16;
            default: begin
                r = us >>> SH;
                if (r < 0) r = 0;
                if (r > MAXP) r = MAXP;
            end
        endcase
        return int'(r);
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscomp++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic set_ident();
        for (int i = 0; i < 9; i++) cref[i] = (i == 4) ? 1 : 0;
    endtask

    // One clock: entered and left at the falling edge.
    task automatic cycle();
        int e, a;
        for (int i = 0; i < 9; i++) pix[i*PW +: PW] = PW'(tap[i]);
        #1;
        chk("ready", 64'(prdy), 64'(!(ov && !ordy)));
        if (held_v) begin
            chk("hold_valid", 64'(ov), 64'(1));
            chk("hold_data", 64'(od), 64'(held_d));
        end
        if (ov && ordy) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 64'(ov && ordy), 64'(0));
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("data", 64'(od), 64'(e));
                if (lat_chk) chk("latency", 64'(cyc - a), 64'(4));
            end
        end
        if (pv && prdy) begin
            exp_q.push_back(ref_pix(int'(md), longint'(th)));
            acc_q.push_back(cyc);
            n_acc++;
        end
        if (cwe && ca < 4'd9) cref[ca] = int'($signed(cd));
        held_v = ov && !ordy;
        held_d = od;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pv = 1'b0;
        #1;
        chk("rst_valid", 64'(ov), 64'(0));
        chk("rst_data", 64'(od), 64'(0));
        exp_q.delete();
        acc_q.delete();
        set_ident();
        held_v = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        pv = 1'b0;
        ordy = 1'b1;
        cwe = 1'b0;
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) cycle();
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic fill(int v);
        for (int i = 0; i < 9; i++) tap[i] = v;
    endtask

    task automatic edge_win(int v);
        fill(0);
        tap[0] = v; tap[3] = v; tap[6] = v;
    endtask

    task automatic rand_win();
        for (int i = 0; i < 9; i++) tap[i] = int'($urandom_range(0, MAXP));
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        pv = 1'b0; md = '0; th = '0;
        cwe = 1'b0; ca = '0; cd = '0;
        ordy = 1'b1;
        fill(0);
        pix = '0;
        @(negedge clk);
        do_reset();

        // identity kernel, center tap sweep
        lat_chk = 1'b1;
        md = 2'd3;
        pv = 1'b1;
        for (int c = 0; c <= MAXP; c++) begin
            rand_win();
            tap[4] = c;
            cycle();
        end
        drain();

        // Sobel binary and magnitude
        pv = 1'b1;
        md = 2'd0; th = 5000;
        edge_win(100); cycle();
        fill(50); cycle();
        th = 160000;
        edge_win(100); cycle();
        md = 2'd1;
        edge_win(100); cycle();
        edge_win(10); cycle();
        // box blur
        md = 2'd2;
        fill(255); cycle();
        fill(10); cycle();
        fill(0); cycle();
        drain();

        // kernel rewrite while streaming, then directed windows
        md = 2'd3;
        pv = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cwe = 1'b1;
            ca = 4'(i);
            cd = (i == 4) ? CW'(8) : CW'(-1);
            rand_win();
            cycle();
        end
        ca = 4'd12; cd = CW'(55);
        rand_win(); cycle();
        cwe = 1'b0;
        fill(37); cycle();
        fill(0); tap[4] = 10; cycle();
        fill(10); tap[4] = 0; cycle();
        drain();

        // random backpressure, mixed modes
        lat_chk = 1'b0;
        base = n_acc;
        for (int k = 0; k < 300 && n_acc - base < 20; k++) begin
            pv = 1'b1;
            rand_win();
            md = 2'($urandom_range(0, 3));
            th = TW'($urandom_range(0, 400000));
            ordy = 1'($urandom_range(0, 1));
            cwe = ($urandom_range(0, 3) == 0);
            ca = 4'($urandom_range(0, 9));
            cd = CW'($urandom_range(0, 255));
            cycle();
        end
        chk("bp_accepts", 64'(n_acc - base), 64'(20));
        drain();

        // reset mid-stream flushes in-flight beats
        lat_chk = 1'b1;
        md = 2'd2;
        pv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_win();
            cycle();
        end
        do_reset();
        pv = 1'b0;
        ordy = 1'b1;
        repeat (8) cycle();
        md = 2'd3;
        pv = 1'b1;
        rand_win(); cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscomp);
        $finish;
    end
endmodule
